// File: rtl/uart_pkg.sv
// Shared UART types and frame constants, used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// System-side byte stream into the UART transmitter (valid/ready handshake).
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with occupancy count; shared by the UART transmit and receive paths.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [UART_DATA_BITS-1:0] din_i,
  output logic [UART_DATA_BITS-1:0] dout_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small byte FIFO; bit timing from an internal cycle counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_fifo_if.slave          tx_if,
  output logic                   tx,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic                      busy_q;
  logic                      bit_last;
  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_if.tx_valid),
    .pop_i   (fifo_pop),
    .din_i   (tx_if.tx_data),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_if.tx_ready = !fifo_full;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign bit_last       = (cnt_q == CNT_LAST);

  // Outputs are registered from state_q, so tx/busy/done trail the state by one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = UART_STOP_BIT;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
        end
      end
      START: begin
        tx_d = UART_START_BIT;
        if (bit_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_last) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // Chain straight into the next frame when more bytes are queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= UART_STOP_BIT;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 104 clocks per bit, with a mid-bit sampling receiver model.
module tb_uart_tx_fifo;

  typedef struct {
    int   off;
    logic tx;
    logic busy;
    logic done;
    int   cnt;
  } vec_t;

  localparam int NT = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx, busy, done;
  logic [2:0] fifo_count;

  int         n_cmp = 0;
  int         n_err = 0;
  int         ferr  = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  vec_t       tab[NT];

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_if      (bus),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    t = 0;
    while (!bus.tx_ready && t < 5000) begin
      step();
      t++;
    end
    if (!bus.tx_ready) chk("push_timeout", 32'd0, 32'd1);
    step();
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    step();
    step();
    t = 0;
    while ((busy || fifo_count != 3'd0) && t < 20000) begin
      step();
      t++;
    end
    if (t >= 20000) chk("idle_timeout", 32'd0, 32'd1);
    repeat (10) step();
  endtask

  // Receiver model: detect the falling start edge, then sample each bit at its centre.
  initial begin : rx_model
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (prev === 1'b1 && tx === 1'b0) begin
        repeat (52) @(posedge clk);
        #1;
        if (tx !== 1'b0) ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (104) @(posedge clk);
          #1;
          b[i] = tx;
        end
        repeat (104) @(posedge clk);
        #1;
        if (tx !== 1'b1) ferr++;
        rx_q.push_back(b);
      end
      prev = tx;
    end
  end

  initial begin : main
    int k, dcnt, nacc, ndone, d1, d6, acc6, first_fall, gap, busyg, over, maxc, lows;
    logic acc, gap_pending, saw_full;

    // Expected waveform for 0xA5 (LSB first 1,0,1,0,0,1,0,1), offsets from the push edge.
    tab = '{
      '{0,    1'b1, 1'b0, 1'b0, 1}, '{1,    1'b1, 1'b0, 1'b0, 0},
      '{2,    1'b0, 1'b1, 1'b0, 0}, '{105,  1'b0, 1'b1, 1'b0, 0},
      '{106,  1'b1, 1'b1, 1'b0, 0}, '{209,  1'b1, 1'b1, 1'b0, 0},
      '{210,  1'b0, 1'b1, 1'b0, 0}, '{313,  1'b0, 1'b1, 1'b0, 0},
      '{314,  1'b1, 1'b1, 1'b0, 0}, '{417,  1'b1, 1'b1, 1'b0, 0},
      '{418,  1'b0, 1'b1, 1'b0, 0}, '{521,  1'b0, 1'b1, 1'b0, 0},
      '{522,  1'b0, 1'b1, 1'b0, 0}, '{625,  1'b0, 1'b1, 1'b0, 0},
      '{626,  1'b1, 1'b1, 1'b0, 0}, '{729,  1'b1, 1'b1, 1'b0, 0},
      '{730,  1'b0, 1'b1, 1'b0, 0}, '{833,  1'b0, 1'b1, 1'b0, 0},
      '{834,  1'b1, 1'b1, 1'b0, 0}, '{937,  1'b1, 1'b1, 1'b0, 0},
      '{938,  1'b1, 1'b1, 1'b0, 0}, '{1040, 1'b1, 1'b1, 1'b0, 0},
      '{1041, 1'b1, 1'b1, 1'b1, 0}, '{1042, 1'b1, 1'b0, 1'b0, 0},
      '{1043, 1'b1, 1'b0, 1'b0, 0}
    };

    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d_tx", i), tx, 1'b1);
      chk($sformatf("rst%0d_ready", i), bus.tx_ready, 1'b1);
      chk($sformatf("rst%0d_busy", i), busy, 1'b0);
      chk($sformatf("rst%0d_done", i), done, 1'b0);
      chk($sformatf("rst%0d_count", i), fifo_count, 3'd0);
    end
    rst = 1'b0;
    step();

    // Single byte against the vector table.
    rx_q.delete();
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    k    = 0;
    dcnt = 0;
    for (int off = 0; off <= 1043; off++) begin
      if (off > 0) step();
      if (done) dcnt++;
      while (k < NT && tab[k].off == off) begin
        chk($sformatf("a5_tx@%0d", off), tx, tab[k].tx);
        chk($sformatf("a5_busy@%0d", off), busy, tab[k].busy);
        chk($sformatf("a5_done@%0d", off), done, tab[k].done);
        chk($sformatf("a5_count@%0d", off), fifo_count, tab[k].cnt);
        k++;
      end
    end
    chk("a5_done_pulses", dcnt, 1);
    chk("a5_rx_len", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("a5_rx_byte", rx_q[0], 8'hA5);

    // Burst of six bytes with tx_valid held.
    rx_q.delete();
    ferr = 0;
    bus.tx_data  = 8'h01;
    bus.tx_valid = 1'b1;
    nacc = 0; ndone = 0; d1 = -1; d6 = -1; acc6 = -1; first_fall = -1;
    gap = 0; busyg = 0; over = 0; gap_pending = 1'b0; saw_full = 1'b0;
    for (int c = 0; c < 7000 && ndone < 6; c++) begin
      acc = bus.tx_valid && bus.tx_ready;
      step();
      if (acc) begin
        nacc++;
        if (nacc == 6) begin
          acc6 = c;
          bus.tx_valid = 1'b0;
        end else begin
          bus.tx_data = 8'(nacc + 1);
        end
      end
      if (!bus.tx_ready && !saw_full) begin
        saw_full = 1'b1;
        chk("burst_full_count", fifo_count, 3'd4);
        chk("burst_full_accepts", nacc, 5);
      end
      if (gap_pending) begin
        if (tx !== 1'b0) gap++;
        gap_pending = 1'b0;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = c;
        if (ndone == 6) d6 = c;
        if (ndone < 6) gap_pending = 1'b1;
      end
      if (tx === 1'b0 && first_fall < 0) first_fall = c;
      if (first_fall >= 0 && !busy) busyg++;
      if (fifo_count > 3'd4) over++;
    end
    chk("burst_done_count", ndone, 6);
    chk("burst_full_seen", saw_full, 1'b1);
    chk("burst_sixth_after_done", (acc6 >= d1) && (acc6 - d1 <= 2), 1'b1);
    chk("burst_total_cycles", d6 - first_fall + 1, 6240);
    chk("burst_idle_gaps", gap, 0);
    chk("burst_busy_drops", busyg, 0);
    chk("burst_overflow", over, 0);
    wait_idle();
    chk("burst_rx_len", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      chk($sformatf("burst_rx%0d", i), rx_q[i], 8'(i + 1));
    chk("burst_framing", ferr, 0);

    // Reset during data bit 3 of 0x3C with two bytes queued behind it.
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h3C;
    step();
    bus.tx_data  = 8'h11;
    step();
    bus.tx_data  = 8'h22;
    step();
    bus.tx_valid = 1'b0;
    chk("abort_queued", fifo_count, 3'd2);
    repeat (468) step();
    chk("abort_bit3_tx", tx, 1'b1);
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_tx", tx, 1'b1);
    chk("abort_count", fifo_count, 3'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", bus.tx_ready, 1'b1);
    dcnt = 0;
    lows = 0;
    for (int i = 0; i < 1100; i++) begin
      if (done) dcnt++;
      if (tx !== 1'b1) lows++;
      step();
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_line_idle", lows, 0);
    rx_q.delete();
    ferr = 0;
    push_byte(8'h81);
    wait_idle();
    chk("abort_rx_len", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("abort_rx_81", rx_q[0], 8'h81);
    chk("abort_framing", ferr, 0);

    // Loopback patterns through the receiver model.
    rx_q.delete();
    exp_q = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    foreach (exp_q[i]) push_byte(exp_q[i]);
    wait_idle();
    chk("loop_rx_len", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++)
      chk($sformatf("loop_rx%0d", i), rx_q[i], exp_q[i]);
    chk("loop_framing", ferr, 0);

    // Backpressure: tx_data changes every cycle while valid is held.
    rx_q.delete();
    exp_q.delete();
    bus.tx_valid = 1'b1;
    nacc = 0;
    maxc = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 12000 && nacc < 8; c++) begin
      bus.tx_data = 8'(c * 37 + 5);
      acc = bus.tx_valid && bus.tx_ready;
      step();
      if (acc) begin
        exp_q.push_back(bus.tx_data);
        nacc++;
      end
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (!bus.tx_ready) saw_full = 1'b1;
    end
    bus.tx_valid = 1'b0;
    chk("bp_accepts", nacc, 8);
    chk("bp_full_seen", saw_full, 1'b1);
    chk("bp_max_count", maxc, 4);
    wait_idle();
    chk("bp_rx_len", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("bp_rx%0d", i), rx_q[i], exp_q[i]);
    chk("bp_framing", ferr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
